// File: rtl/mtr_pwm_drv_if.sv
// mtr_pwm_drv_if
//   Bundles the speed inputs, over-current/fault-clear controls and the gate/status
//   outputs of mtr_pwm_drv. clk and rst are plain ports on the module, not part of
//   this bundle.
// Signals
//   lft_spd   [11:0] signed left speed (two's complement)
//   rght_spd  [11:0] signed right speed
//   OVR_I            bridge over-current comparator, synchronised, active high
//   clr_fault        one-clock fault clear request
//   PWM1_lft/PWM2_lft, PWM1_rght/PWM2_rght   high-/low-side gates per motor
//   fault            latched over-current shutdown
//   prd_strt         one-clock pulse on the first clock of each PWM period
// Modports
//   master : speed/control source (drives inputs, observes gates)
//   slave  : the driver itself
`timescale 1ns/1ps
interface mtr_pwm_drv_if;
   logic [11:0] lft_spd;
   logic [11:0] rght_spd;
   logic        OVR_I;
   logic        clr_fault;
   logic        PWM1_lft;
   logic        PWM2_lft;
   logic        PWM1_rght;
   logic        PWM2_rght;
   logic        fault;
   logic        prd_strt;

   modport master (
      output lft_spd, rght_spd, OVR_I, clr_fault,
      input  PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, fault, prd_strt
   );

   modport slave (
      input  lft_spd, rght_spd, OVR_I, clr_fault,
      output PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, fault, prd_strt
   );
endinterface

// File: rtl/mtr_pwm_drv.sv
// mtr_pwm_drv
//   Converts saturated signed left/right speeds into complementary high-/low-side
//   gate PWM per motor with fixed dead time, and shuts the bridge down after
//   OVR_LIMIT consecutive PWM periods with a blanked over-current indication.
//   Period is 2048 clocks (11-bit free-running counter).
// Ports
//   clk  in   system clock
//   rst  in   asynchronous active-high reset
//   bus  mtr_pwm_drv_if.slave : speeds, OVR_I, clr_fault in; gates, fault, prd_strt out
// Configuration
//   DUTY_SLEW_EN (define) : duty register steps toward its target by at most
//   SLEW_STEP per period instead of loading the target directly.
`timescale 1ns/1ps
module mtr_pwm_drv #(
   parameter logic [10:0] DEAD_TIME = 11'd32,
   parameter logic [10:0] BLANK     = 11'd128,
   parameter logic [2:0]  OVR_LIMIT = 3'd4,
   parameter logic [10:0] SLEW_STEP = 11'd16
) (
   input logic          clk,
   input logic          rst,
   mtr_pwm_drv_if.slave bus
);

   typedef enum logic {RUN, TRIP} state_t;

   state_t      state, state_nxt;
   logic [10:0] cnt;
   logic [10:0] duty_lft, duty_rght;
   logic [10:0] tgt_lft, tgt_rght;
   logic [10:0] duty_lft_nxt, duty_rght_nxt;
   logic [2:0]  ovr_cnt;
   logic        ovr_seen;
   logic        clr_pend;
   logic        clr_req;
   logic        prd_end;
   logic        ovr_win;
   logic        fault_int;
   logic        pwm1_lft, pwm2_lft, pwm1_rght, pwm2_rght;
   logic        prd_strt_r;
   logic        spd_lsb_unused;

   // Speed LSBs are dropped by the offset-binary conversion.
   assign spd_lsb_unused = bus.lft_spd[0] ^ bus.rght_spd[0];

   // Signed speed -> offset binary duty: 0 speed sits at 50%.
   assign tgt_lft  = {~bus.lft_spd[11],  bus.lft_spd[10:1]};
   assign tgt_rght = {~bus.rght_spd[11], bus.rght_spd[10:1]};

   assign prd_end = (cnt == '1);

   // Current-sense window opens after dead time plus blanking and stays open while
   // either high side is on.
   assign ovr_win = ({1'b0, cnt} >= ({1'b0, DEAD_TIME} + {1'b0, BLANK})) &&
                    ((cnt < duty_lft) || (cnt < duty_rght));

   // A clear arriving on the boundary clock itself is honoured at that boundary.
   assign clr_req = clr_pend | bus.clr_fault;

`ifdef DUTY_SLEW_EN
   function automatic logic [10:0] slew(input logic [10:0] cur, input logic [10:0] tgt);
      // cur +/- SLEW_STEP is only taken when the target lies further away, so the
      // result stays inside 0..2047 without extra saturation logic.
      if (tgt > cur)
         return ((tgt - cur) > SLEW_STEP) ? cur + SLEW_STEP : tgt;
      else
         return ((cur - tgt) > SLEW_STEP) ? cur - SLEW_STEP : tgt;
   endfunction

   always_comb begin
      duty_lft_nxt  = slew(duty_lft,  tgt_lft);
      duty_rght_nxt = slew(duty_rght, tgt_rght);
   end
`else
   always_comb begin
      duty_lft_nxt  = tgt_lft;
      duty_rght_nxt = tgt_rght;
   end
`endif

   // Fault FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= RUN;
      else
         state <= state_nxt;
   end

   // Fault FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (ovr_cnt >= OVR_LIMIT) state_nxt = TRIP;
         TRIP:    if (prd_end && clr_req)   state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // Fault FSM: outputs
   always_comb begin
      fault_int = (state == TRIP);
   end

   // Counter, duty registers, over-current bookkeeping and registered gates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         duty_lft   <= 11'h400;
         duty_rght  <= 11'h400;
         ovr_cnt    <= '0;
         ovr_seen   <= 1'b0;
         clr_pend   <= 1'b0;
         pwm1_lft   <= 1'b0;
         pwm2_lft   <= 1'b0;
         pwm1_rght  <= 1'b0;
         pwm2_rght  <= 1'b0;
         prd_strt_r <= 1'b0;
      end else begin
         cnt <= cnt + 11'd1;

         if (prd_end) begin
            duty_lft  <= duty_lft_nxt;
            duty_rght <= duty_rght_nxt;
         end

         if (prd_end) begin
            ovr_seen <= 1'b0;
            if (state == TRIP && clr_req)
               ovr_cnt <= '0;
            else if (ovr_seen)
               ovr_cnt <= (ovr_cnt >= OVR_LIMIT) ? ovr_cnt : ovr_cnt + 3'd1;
            else
               ovr_cnt <= '0;
         end else if (ovr_win && bus.OVR_I) begin
            ovr_seen <= 1'b1;
         end

         // Only requests seen while tripped are kept; a clear coinciding with the
         // trip clock is therefore discarded.
         if (state != TRIP || prd_end)
            clr_pend <= 1'b0;
         else if (bus.clr_fault)
            clr_pend <= 1'b1;

         pwm1_lft  <= !fault_int && (cnt >= DEAD_TIME) && (cnt < duty_lft);
         pwm1_rght <= !fault_int && (cnt >= DEAD_TIME) && (cnt < duty_rght);
         pwm2_lft  <= !fault_int &&
                      ({1'b0, cnt} >= ({1'b0, duty_lft} + {1'b0, DEAD_TIME}));
         pwm2_rght <= !fault_int &&
                      ({1'b0, cnt} >= ({1'b0, duty_rght} + {1'b0, DEAD_TIME}));

         prd_strt_r <= (cnt == '0);
      end
   end

   assign bus.PWM1_lft  = pwm1_lft;
   assign bus.PWM2_lft  = pwm2_lft;
   assign bus.PWM1_rght = pwm1_rght;
   assign bus.PWM2_rght = pwm2_rght;
   assign bus.fault     = fault_int;
   assign bus.prd_strt  = prd_strt_r;

endmodule
